// File: rtl/rnn_seq_loader.sv
`default_nettype none
// ============================================================================
//  Module   : rnn_seq_loader
//  Purpose  : Input stage for the RNN core. Synchronises an asynchronous
//             pad strobe, buffers bytes in a show-ahead FIFO and streams
//             them over valid/ready, tagging each with its sequence step.
//  Revision : 1.0 - initial release
// ============================================================================
module rnn_seq_loader #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SEQ_LEN     = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       wr_strobe,
  input  logic                       flush,
  output logic [DATA_W-1:0]          x_data,
  output logic                       x_valid,
  input  logic                       x_ready,
  output logic                       x_first,
  output logic                       x_last,
  output logic [$clog2(SEQ_LEN)-1:0] step_idx,
  output logic                       fifo_full,
  output logic                       overflow
);

  localparam int unsigned C_AW = $clog2(DEPTH);
  localparam int unsigned C_SW = $clog2(SEQ_LEN);
  localparam logic [C_SW-1:0] C_STEP_LAST = C_SW'(SEQ_LEN - 1);

  // Pad synchronisers and strobe edge detector
  logic [SYNC_STAGES-1:0] r_strobe_sync;
  logic [SYNC_STAGES-1:0] r_flush_sync;
  logic                   r_strobe_prev;

  // FIFO storage and pointers (one extra MSB distinguishes full from empty)
  logic [DATA_W-1:0]      r_mem [DEPTH];
  logic [C_AW:0]          r_wr_ptr;
  logic [C_AW:0]          r_rd_ptr;
  logic [C_SW-1:0]        r_step;
  logic                   r_overflow;

  logic                   w_write_ev;
  logic                   w_flush;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;

  // Shift the pad levels through the synchronisers; these run even when frozen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_strobe_sync <= '0;
      r_flush_sync  <= '0;
      r_strobe_prev <= 1'b0;
    end else begin
      r_strobe_sync <= {r_strobe_sync[SYNC_STAGES-2:0], wr_strobe};
      r_flush_sync  <= {r_flush_sync[SYNC_STAGES-2:0], flush};
      r_strobe_prev <= r_strobe_sync[SYNC_STAGES-1];
    end
  end

  // Qualify writes, pops and drops; flush and freeze override both sides
  always_comb begin
    w_write_ev = r_strobe_sync[SYNC_STAGES-1] & ~r_strobe_prev;
    w_flush    = ena & r_flush_sync[SYNC_STAGES-1];
    w_empty    = (r_wr_ptr == r_rd_ptr);
    w_full     = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                 (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
    w_pop      = ena & ~w_empty & x_ready & ~w_flush;
    w_push     = ena & w_write_ev & (~w_full | w_pop) & ~w_flush;
    w_drop     = ena & w_write_ev & w_full & ~w_pop & ~w_flush;
  end

  // Data is captured straight from the pad at the write edge; the host holds it stable
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[C_AW-1:0]] <= data_in;
    end
  end

  // Pointer, step counter and sticky overflow bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_step     <= '0;
      r_overflow <= 1'b0;
    end else if (w_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_step     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        // SEQ_LEN is a power of two, so the counter wraps to 0 on its own
        r_step   <= r_step + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Head sample is presented combinationally; zero when nothing is queued
  always_comb begin
    x_data    = w_empty ? '0 : r_mem[r_rd_ptr[C_AW-1:0]];
    x_valid   = ena & ~w_empty;
    x_first   = x_valid & (r_step == '0);
    x_last    = x_valid & (r_step == C_STEP_LAST);
    step_idx  = r_step;
    fifo_full = w_full;
    overflow  = r_overflow;
  end

endmodule
`default_nettype wire
